// File: rtl/segment_encap.sv
// segment_encap: splits one DFX word into NUM_SEG Aurora segments, each {payload, seq, ttl, router_id}.
// Define SEGMENT_ENCAP_PREFETCH_EN to add a pending buffer for zero-bubble back-to-back packets.
module segment_encap #(
    parameter int DATA_WIDTH             = 1024,
    parameter int ADDR_WIDTH             = 10,
    parameter int DATA_DFX_WIDTH         = DATA_WIDTH + ADDR_WIDTH,
    parameter int RECOGNIZE_ROUTER_WIDTH = 2,
    parameter int TTL_WIDTH              = 2,
    parameter int AURORA_DATA_WIDTH      = 64,
    parameter int SEQ_WIDTH              = 5,
    parameter int HEADER_WIDTH           = RECOGNIZE_ROUTER_WIDTH + SEQ_WIDTH + TTL_WIDTH,
    parameter int PAYLOAD_WIDTH          = AURORA_DATA_WIDTH - HEADER_WIDTH,
    parameter int NUM_SEG                = (DATA_DFX_WIDTH + PAYLOAD_WIDTH - 1) / PAYLOAD_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_DFX_WIDTH-1:0]         in_data,
    input  logic [RECOGNIZE_ROUTER_WIDTH-1:0] in_router_id,
    input  logic [TTL_WIDTH-1:0]              in_ttl,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [AURORA_DATA_WIDTH-1:0]      m_data,
    output logic                              m_valid,
    output logic                              m_last,
    input  logic                              m_ready,
    output logic [15:0]                       pkt_cnt
);

    localparam int PADDED_WIDTH = NUM_SEG * PAYLOAD_WIDTH;
    localparam logic [SEQ_WIDTH-1:0] LAST_SEG = SEQ_WIDTH'(NUM_SEG - 1);

    generate
        if (PAYLOAD_WIDTH <= 0 || NUM_SEG > (1 << SEQ_WIDTH)) begin : g_param_check
            $fatal(1, "segment_encap: header leaves no payload or NUM_SEG exceeds sequence range");
        end
    endgenerate

    typedef enum logic {IDLE, SEND} state_t;

    state_t                              state_q, state_d;
    logic [SEQ_WIDTH-1:0]                seg_q, seg_d;
    logic [DATA_DFX_WIDTH-1:0]           buf_q, buf_d;
    logic [RECOGNIZE_ROUTER_WIDTH-1:0]   rid_q, rid_d;
    logic [TTL_WIDTH-1:0]                ttl_q, ttl_d;
    logic [15:0]                         pkt_cnt_q, pkt_cnt_d;
    logic [AURORA_DATA_WIDTH-1:0]        m_data_q, m_data_d;
    logic                                m_last_q, m_last_d;
    logic                                accept, seg_hs, last_hs;

`ifdef SEGMENT_ENCAP_PREFETCH_EN
    logic [DATA_DFX_WIDTH-1:0]           pend_buf_q, pend_buf_d;
    logic [RECOGNIZE_ROUTER_WIDTH-1:0]   pend_rid_q, pend_rid_d;
    logic [TTL_WIDTH-1:0]                pend_ttl_q, pend_ttl_d;
    logic                                pend_valid_q, pend_valid_d;

    assign in_ready = !rst && !pend_valid_q;
`else
    assign in_ready = !rst && (state_q == IDLE);
`endif

    // Zero-extend the word to a whole number of segments so the last one carries pad bits.
    function automatic logic [AURORA_DATA_WIDTH-1:0] pack_seg(
        input logic [DATA_DFX_WIDTH-1:0]         word,
        input logic [SEQ_WIDTH-1:0]              seg,
        input logic [TTL_WIDTH-1:0]              ttl,
        input logic [RECOGNIZE_ROUTER_WIDTH-1:0] rid
    );
        logic [PADDED_WIDTH-1:0] padded;
        padded = '0;
        padded[DATA_DFX_WIDTH-1:0] = word;
        return {padded[int'(seg)*PAYLOAD_WIDTH +: PAYLOAD_WIDTH], seg, ttl, rid};
    endfunction

    assign accept  = in_valid && in_ready;
    assign seg_hs  = (state_q == SEND) && m_ready;
    assign last_hs = seg_hs && (seg_q == LAST_SEG);

    always_comb begin
        state_d   = state_q;
        seg_d     = seg_q;
        buf_d     = buf_q;
        rid_d     = rid_q;
        ttl_d     = ttl_q;
        pkt_cnt_d = pkt_cnt_q;
`ifdef SEGMENT_ENCAP_PREFETCH_EN
        pend_buf_d   = pend_buf_q;
        pend_rid_d   = pend_rid_q;
        pend_ttl_d   = pend_ttl_q;
        pend_valid_d = pend_valid_q;
`endif
        if (seg_hs) begin
            if (last_hs) begin
                state_d   = IDLE;
                seg_d     = '0;
                pkt_cnt_d = pkt_cnt_q + 16'd1;
            end else begin
                seg_d = seg_q + 1'b1;
            end
        end
`ifdef SEGMENT_ENCAP_PREFETCH_EN
        // The active buffer is free in IDLE or on the edge its last segment leaves.
        if (state_q == IDLE || last_hs) begin
            if (pend_valid_q) begin
                buf_d        = pend_buf_q;
                rid_d        = pend_rid_q;
                ttl_d        = pend_ttl_q;
                pend_valid_d = 1'b0;
                state_d      = SEND;
                seg_d        = '0;
            end else if (accept) begin
                buf_d   = in_data;
                rid_d   = in_router_id;
                ttl_d   = in_ttl;
                state_d = SEND;
                seg_d   = '0;
            end
        end else if (accept) begin
            pend_buf_d   = in_data;
            pend_rid_d   = in_router_id;
            pend_ttl_d   = in_ttl;
            pend_valid_d = 1'b1;
        end
`else
        if (accept) begin
            buf_d   = in_data;
            rid_d   = in_router_id;
            ttl_d   = in_ttl;
            state_d = SEND;
            seg_d   = '0;
        end
`endif
        m_data_d = (state_d == SEND) ? pack_seg(buf_d, seg_d, ttl_d, rid_d) : '0;
        m_last_d = (state_d == SEND) && (seg_d == LAST_SEG);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            seg_q     <= '0;
            buf_q     <= '0;
            rid_q     <= '0;
            ttl_q     <= '0;
            pkt_cnt_q <= '0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
`ifdef SEGMENT_ENCAP_PREFETCH_EN
            pend_buf_q   <= '0;
            pend_rid_q   <= '0;
            pend_ttl_q   <= '0;
            pend_valid_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            seg_q     <= seg_d;
            buf_q     <= buf_d;
            rid_q     <= rid_d;
            ttl_q     <= ttl_d;
            pkt_cnt_q <= pkt_cnt_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
`ifdef SEGMENT_ENCAP_PREFETCH_EN
            pend_buf_q   <= pend_buf_d;
            pend_rid_q   <= pend_rid_d;
            pend_ttl_q   <= pend_ttl_d;
            pend_valid_q <= pend_valid_d;
`endif
        end
    end

    assign m_valid = (state_q == SEND);
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign pkt_cnt = pkt_cnt_q;

endmodule

// File: doc/segment_encap.md
# segment_encap

Parametrised packet segmenter for input port 0. It accepts one DFX word (data plus address) and converts it into a stream of Aurora-width segments. Each segment carries a per-segment header: router ID, TTL and a segment sequence number. The block sits between the port arbiter/DFX source and the Aurora TX user interface. Unlike the previous generation, it honours downstream backpressure, marks the last segment and inserts sequence numbers itself.

## Interface
Parameters:
- DATA_WIDTH, 1024, payload data bits of a DFX word
- ADDR_WIDTH, 10, address bits appended to the DFX word
- DATA_DFX_WIDTH, DATA_WIDTH+ADDR_WIDTH, total input word width
- RECOGNIZE_ROUTER_WIDTH, 2, router ID field width
- TTL_WIDTH, 2, TTL field width
- AURORA_DATA_WIDTH, 64, output segment width
- SEQ_WIDTH, 5, sequence field width
- HEADER_WIDTH, RECOGNIZE_ROUTER_WIDTH+SEQ_WIDTH+TTL_WIDTH (9), header width
- PAYLOAD_WIDTH, AURORA_DATA_WIDTH-HEADER_WIDTH (55), payload bits per segment
- NUM_SEG, ceil(DATA_DFX_WIDTH/PAYLOAD_WIDTH) (19), segments per packet

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_data  in  DATA_DFX_WIDTH  DFX word to send
- in_router_id  in  RECOGNIZE_ROUTER_WIDTH  destination router, sampled with in_data
- in_ttl  in  TTL_WIDTH  TTL, sampled with in_data
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word
- m_data  out  AURORA_DATA_WIDTH  segment {payload, seq, ttl, router_id}, router_id in LSBs
- m_valid  out  1  segment valid
- m_last  out  1  high on segment NUM_SEG-1
- m_ready  in  1  downstream accepts segment
- pkt_cnt  out  16  count of fully sent packets, wraps at 2^16

## Operation
- Elaboration checks: PAYLOAD_WIDTH>0 and NUM_SEG<=2^SEQ_WIDTH; a violation is a fatal error.
- Input handshake: in_valid&&in_ready at a rising edge captures in_data, in_router_id and in_ttl into the active buffer.
- in_ready is derived from registered state only and never depends on in_valid.
- States:
  - IDLE: m_valid=0, in_ready=1. An accept moves to SEND with seg=0.
  - SEND: m_valid=1, m_data=segment seg.
- Segment k payload = buffer[k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]. Bits beyond DATA_DFX_WIDTH are zero (default: the last segment carries 44 data bits plus 11 zero bits). The seq field = k.
- Advance on m_valid&&m_ready:
  - seg<NUM_SEG-1: seg increments.
  - seg==NUM_SEG-1: pkt_cnt increments, then go to IDLE, or to the next packet (see Configuration).
- With m_ready low, m_data, m_valid and m_last hold stable. This is AXI-stream compliant: no retraction.
- m_last = (seg==NUM_SEG-1) && m_valid.
- Reset (any time, including mid-packet): drop the current and any pending packet. Outputs:
  - m_data=0, m_valid=0, m_last=0, pkt_cnt=0
  - in_ready=0 while rst is high, 1 on the first cycle after.
- No partial packet is ever emitted after reset.

## Timing
- Accept at edge N: segment 0 is valid from N+1 (latency 1).
- With m_ready held high, one segment is emitted per cycle, so the packet occupies cycles N+1..N+NUM_SEG.
- Without prefetch: in_ready is high only in IDLE. Back-to-back packets have period NUM_SEG+1 cycles (one accept cycle with m_valid=0).
- Simultaneous last-segment handshake and in_valid: without prefetch the new word is not accepted that cycle, because in_ready=0.
- pkt_cnt updates on the edge of the last handshake.

## Configuration
- Macro: SEGMENT_ENCAP_PREFETCH_EN.
- Defined: adds a pending buffer plus a pending-valid flag.
  - in_ready = !pending_valid, in any state.
  - An accept in IDLE loads the active buffer directly.
  - An accept in SEND loads the pending buffer.
  - When the last-segment handshake occurs and a pending word exists (or is accepted on the same edge), it moves to the active buffer. Segment 0 of that packet is valid the next cycle: zero bubble, period NUM_SEG cycles.
  - Reset clears pending_valid.
- Undefined: single buffer, behaviour as described in Operation.

## Test plan
- Single packet, in_data = incrementing byte pattern, router_id=2'b01, ttl=2'b10, m_ready=1 -> 19 segments on consecutive cycles.
  - Segment k has seq=k and payload bits[k*55+:55].
  - Segment 18 has 11 zero pad bits and m_last=1.
  - pkt_cnt=1.
- Backpressure: m_ready toggles 1,0,0,1 repeatedly -> m_data stable during stalls, no segment lost or duplicated, total 19 handshakes.
- Back-to-back, in_valid held high with 3 packets, m_ready=1:
  - Macro undefined -> period 20 cycles.
  - Macro defined -> period 19 cycles, with m_valid continuously high for 57 cycles.
- Prefetch corner (macro defined): second word offered exactly on the last-segment cycle of packet 1 -> accepted, segment 0 of packet 2 appears the next cycle.
- Reset asserted during segment 7 -> next cycle m_valid=0, pkt_cnt=0. A following packet starts cleanly at seq 0.
- pkt_cnt wrap: send 65536 packets (or force pkt_cnt=16'hFFFF) -> next completed packet gives pkt_cnt=0.
